tdm_unit: RTL and testbench



---
 rtl/tdm_unit.sv | 193 +++++++++++++++++++
 tb/tb_tdm_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_unit.sv
// rtl/tdm_unit.sv - multi-channel I2S / left-justified / TDM audio serializer
module tdm_unit #(
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int SCK_HALF     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             play_in,
  input  logic                             tick_in,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] audio_in,
  input  logic [1:0]                       mode_in,
  output logic                             req_out,
  output logic                             underrun_out,
  output logic                             ws_out,
  output logic                             sck_out,
  output logic                             sdo_out
);
  localparam int F  = CHANNELS * SLOT_WIDTH;
  localparam int BW = $clog2(F);
  localparam int PW = $clog2(2 * SCK_HALF);
  localparam int DW = CHANNELS * SAMPLE_WIDTH;

  localparam logic [BW-1:0] LAST_BIT = BW'(F - 1);
  localparam logic [BW-1:0] HALF_BIT = BW'((CHANNELS / 2) * SLOT_WIDTH);
  localparam logic [BW-1:0] HALF_M1  = BW'((CHANNELS / 2) * SLOT_WIDTH - 1);
  localparam logic [PW-1:0] LAST_PH  = PW'(2 * SCK_HALF - 1);
  localparam logic [PW-1:0] HIGH_PH  = PW'(SCK_HALF);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [F-1:0]  frame_q, frame_d;
  logic          prev_q, prev_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          valid_q, valid_d;
  logic          req_q, req_d;
  logic          underrun_q, underrun_d;
  logic          ws_q, ws_d;
  logic          sck_q, sck_d;
  logic          sdo_q, sdo_d;

  logic [F-1:0]  fmt;
  logic          last_ph, frame_end, load, active, lj_bit, dl_bit;
  logic [BW-1:0] lj_idx;

  // Frame bit 0 lives at the MSB of the frame register.
  always_comb begin
    fmt = '0;
    for (int k = 0; k < CHANNELS; k++)
      fmt[F-1-k*SLOT_WIDTH -: SAMPLE_WIDTH] = buf_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    prev_d     = prev_q;
    mode_d     = mode_q;
    buf_d      = buf_q;
    valid_d    = valid_q;
    req_d      = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;
    last_ph    = (ph_q == LAST_PH);
    frame_end  = last_ph && (bit_q == LAST_BIT);
    case (state_q)
      S_IDLE: begin
        ph_d    = '0;
        bit_d   = '0;
        prev_d  = 1'b0;
        valid_d = 1'b0;
        if (play_in) begin
          state_d = S_FILL;
          req_d   = 1'b1;
        end
      end
      S_FILL: begin
        if (!play_in) begin
          state_d = S_IDLE;
        end else if (valid_q) begin
          load    = 1'b1;
          state_d = S_RUN;
          ph_d    = '0;
          bit_d   = '0;
          prev_d  = 1'b0;
        end
      end
      default: begin
        ph_d = last_ph ? '0 : ph_q + 1'b1;
        if (last_ph) bit_d = frame_end ? '0 : bit_q + 1'b1;
        if (frame_end) begin
          if (play_in) begin
            load       = 1'b1;
            state_d    = S_RUN;
            req_d      = 1'b1;
            underrun_d = !valid_q;
            prev_d     = frame_q[0];
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = play_in ? S_RUN : S_STOP;
        end
      end
    endcase
    if (load) begin
      frame_d = valid_q ? fmt : '0;
      mode_d  = (mode_in == 2'b11) ? 2'b01 : mode_in;
      valid_d = 1'b0;
    end
    // A tick landing on the load cycle survives for the following frame.
    if (tick_in && (state_q != S_IDLE)) begin
      buf_d   = audio_in;
      valid_d = 1'b1;
    end
  end

  // Outputs are derived from next-state values so they register in step with the counters.
  always_comb begin
    active = (state_d == S_RUN) || (state_d == S_STOP);
    lj_idx = LAST_BIT - bit_d;
    lj_bit = frame_d[lj_idx];
    dl_bit = (bit_d == '0) ? prev_d : frame_d[lj_idx + 1'b1];
    sck_d  = 1'b0;
    sdo_d  = 1'b0;
    ws_d   = 1'b0;
    if (active) begin
      sck_d = (ph_d >= HIGH_PH);
      case (mode_d)
        2'b00: begin
          sdo_d = dl_bit;
          ws_d  = (bit_d != LAST_BIT) && (bit_d >= HALF_M1);
        end
        2'b10: begin
          sdo_d = dl_bit;
          ws_d  = (bit_d == LAST_BIT) && (state_d == S_RUN);
        end
        default: begin
          sdo_d = lj_bit;
          ws_d  = (bit_d >= HALF_BIT);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      prev_q     <= 1'b0;
      mode_q     <= 2'b00;
      buf_q      <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      underrun_q <= 1'b0;
      ws_q       <= 1'b0;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      prev_q     <= prev_d;
      mode_q     <= mode_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      underrun_q <= underrun_d;
      ws_q       <= ws_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
    end
  end

  assign req_out      = req_q;
  assign underrun_out = underrun_q;
  assign ws_out       = ws_q;
  assign sck_out      = sck_q;
  assign sdo_out      = sdo_q;

endmodule

// File: tb/tb_tdm_unit.sv
// tb/tb_tdm_unit.sv - directed self-checking bench for tdm_unit
module tb_tdm_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        play_a, tick_a, req_a, und_a, ws_a, sck_a, sdo_a;
  logic [47:0] audio_a;
  logic [1:0]  mode_a;
  logic        play_b, tick_b, req_b, und_b, ws_b, sck_b, sdo_b;
  logic [95:0] audio_b;
  logic [1:0]  mode_b;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int req_last_a = 0;
  int req_gap_a = 0;

  localparam logic [63:0]  LJ_A    = {24'h800001, 8'h00, 24'h7FFFFE, 8'h00};
  localparam logic [63:0]  LJ_B    = {24'h123456, 8'h00, 24'hABCDEF, 8'h00};
  localparam logic [63:0]  WS_LJ   = {32'h0, 32'hFFFFFFFF};
  localparam logic [63:0]  WS_I2S  = {31'h0, 32'hFFFFFFFF, 1'b0};
  localparam logic [127:0] LJ_T    = {24'hA00000, 8'h00, 24'h500000, 8'h00,
                                      24'hF00000, 8'h00, 24'h000001, 8'h00};

  tdm_unit dut_a (
    .clk(clk), .rst_n(rst_n), .play_in(play_a), .tick_in(tick_a), .audio_in(audio_a),
    .mode_in(mode_a), .req_out(req_a), .underrun_out(und_a), .ws_out(ws_a),
    .sck_out(sck_a), .sdo_out(sdo_a)
  );

  tdm_unit #(.CHANNELS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .play_in(play_b), .tick_in(tick_b), .audio_in(audio_b),
    .mode_in(mode_b), .req_out(req_b), .underrun_out(und_b), .ws_out(ws_b),
    .sck_out(sck_b), .sdo_out(sdo_b)
  );

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (req_a === 1'b1) begin
      req_gap_a = cyc_cnt - req_last_a;
      req_last_a = cyc_cnt;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_play(input int sel, input logic v);
    if (sel == 0) play_a = v;
    else play_b = v;
  endtask

  task automatic set_tick(input int sel, input logic v);
    if (sel == 0) tick_a = v;
    else tick_b = v;
  endtask

  // Entered one step after the edge that starts bit 0; returns one step after the next frame starts.
  task automatic capture(input int sel, input int nbits, input int tick_cyc, input int drop_bit,
                         input int raise_bit, output logic [127:0] sdo_v, output logic [127:0] ws_v,
                         output logic req0, output logic und0, output int extra, output int bad);
    logic r, u, w, s, d, cw, cd;
    sdo_v = '0; ws_v = '0; req0 = 1'b0; und0 = 1'b0; extra = 0; bad = 0; cw = 1'b0; cd = 1'b0;
    for (int i = 0; i < nbits * 4; i++) begin
      @(negedge clk);
      if (sel == 0) begin r = req_a; u = und_a; w = ws_a; s = sck_a; d = sdo_a; end
      else begin r = req_b; u = und_b; w = ws_b; s = sck_b; d = sdo_b; end
      if (s !== ((i % 4) >= 2)) bad++;
      if (i % 4 == 0) begin
        sdo_v = {sdo_v[126:0], d};
        ws_v  = {ws_v[126:0], w};
        cw = w;
        cd = d;
      end else if (w !== cw || d !== cd) begin
        bad++;
      end
      if (i == 0) begin
        req0 = r;
        und0 = u;
      end else if (r === 1'b1 || u === 1'b1) begin
        extra++;
      end
      @(posedge clk); #1;
      set_tick(sel, (i + 1) == tick_cyc);
      if ((i + 1) == drop_bit * 4) set_play(sel, 1'b0);
      if ((i + 1) == raise_bit * 4) set_play(sel, 1'b1);
    end
  endtask

  initial begin
    logic [127:0] sv, wv;
    logic r0, u0;
    int ex, bad, cnt;

    rst_n = 1'b0;
    play_a = 1'b0; tick_a = 1'b0; audio_a = '0; mode_a = 2'b01;
    play_b = 1'b0; tick_b = 1'b0; audio_b = '0; mode_b = 2'b10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", {req_a, und_a, ws_a, sck_a, sdo_a}, 0);
    check("reset_b", {req_b, und_b, ws_b, sck_b, sdo_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    audio_a = {24'h7FFFFE, 24'h800001};
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick_a = i[0];
      @(negedge clk);
      if ({req_a, und_a, ws_a, sck_a, sdo_a} !== 5'b0) cnt++;
      @(posedge clk); #1;
    end
    tick_a = 1'b0;
    check("idle_ticks_quiet", cnt, 0);

    play_a = 1'b1;
    @(negedge clk);
    check("req_at_t", req_a, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("req_at_t1", req_a, 1);
    tick_a = 1'b1;
    @(posedge clk); #1;
    tick_a = 1'b0;
    @(negedge clk);
    check("quiet_at_u1", {req_a, ws_a, sck_a, sdo_a}, 0);
    @(posedge clk); #1;

    capture(0, 64, 8, -1, -1, sv, wv, r0, u0, ex, bad);
    check("lj_f1_sdo", sv, {64'h0, LJ_A});
    check("lj_f1_ws", wv, {64'h0, WS_LJ});
    check("lj_f1_req0", r0, 0);
    check("lj_f1_timing", bad, 0);
    check("lj_f1_extra", ex, 0);

    capture(0, 64, 8, -1, -1, sv, wv, r0, u0, ex, bad);
    check("lj_f2_sdo", sv, {64'h0, LJ_A});
    check("lj_f2_req_und", {r0, u0}, 2'b10);

    mode_a = 2'b00;
    capture(0, 64, 8, -1, -1, sv, wv, r0, u0, ex, bad);
    check("lj_f3_sdo_mode_held", sv, {64'h0, LJ_A});
    check("lj_f3_ws", wv, {64'h0, WS_LJ});
    check("req_period", req_gap_a, 256);

    capture(0, 64, -1, -1, -1, sv, wv, r0, u0, ex, bad);
    check("i2s_sdo", sv, {64'h0, 1'b0, LJ_A[63:1]});
    check("i2s_ws", wv, {64'h0, WS_I2S});
    check("i2s_req_und", {r0, u0}, 2'b10);
    check("i2s_timing", bad, 0);

    mode_a = 2'b01;
    audio_a = {24'hABCDEF, 24'h123456};
    capture(0, 64, 255, -1, -1, sv, wv, r0, u0, ex, bad);
    check("underrun_sdo", sv, 0);
    check("underrun_ws", wv, {64'h0, WS_I2S});
    check("underrun_req_und", {r0, u0}, 2'b11);

    capture(0, 64, -1, -1, -1, sv, wv, r0, u0, ex, bad);
    check("collide_sdo", sv, 0);
    check("collide_ws", wv, {64'h0, WS_LJ});
    check("collide_req_und", {r0, u0}, 2'b11);

    capture(0, 64, 8, 10, 20, sv, wv, r0, u0, ex, bad);
    check("after_collide_sdo", sv, {64'h0, LJ_B});
    check("after_collide_req_und", {r0, u0}, 2'b10);
    check("resume_extra", ex, 0);
    check("resume_timing", bad, 0);

    capture(0, 64, -1, 10, -1, sv, wv, r0, u0, ex, bad);
    check("resume_next_sdo", sv, {64'h0, LJ_B});
    check("resume_next_req", {r0, u0}, 2'b10);
    check("stop_extra", ex, 0);

    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({req_a, und_a, ws_a, sck_a, sdo_a} !== 5'b0) cnt++;
      @(posedge clk); #1;
    end
    check("stop_to_idle", cnt, 0);

    audio_b = {24'h000001, 24'hF00000, 24'h500000, 24'hA00000};
    play_b = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("tdm_req", req_b, 1);
    tick_b = 1'b1;
    @(posedge clk); #1;
    tick_b = 1'b0;
    @(posedge clk); #1;

    capture(1, 128, 8, -1, -1, sv, wv, r0, u0, ex, bad);
    check("tdm_f1_sdo", sv, {1'b0, LJ_T[127:1]});
    check("tdm_f1_ws", wv, 128'h1);
    check("tdm_f1_timing", bad, 0);

    capture(1, 128, -1, 100, -1, sv, wv, r0, u0, ex, bad);
    check("tdm_f2_sdo", sv, {1'b0, LJ_T[127:1]});
    check("tdm_f2_ws", wv, 0);
    check("tdm_f2_req_und", {r0, u0}, 2'b10);
    @(negedge clk);
    check("tdm_idle", {req_b, und_b, ws_b, sck_b, sdo_b}, 0);
    @(posedge clk); #1;

    mode_a = 2'b00;
    play_a = 1'b1;
    @(posedge clk); #1;
    tick_a = 1'b1;
    @(posedge clk); #1;
    tick_a = 1'b0;
    @(posedge clk); #1;
    capture(0, 64, -1, -1, -1, sv, wv, r0, u0, ex, bad);
    check("i2s_first_sdo", sv, {64'h0, 1'b0, LJ_B[63:1]});
    check("i2s_first_ws", wv, {64'h0, WS_I2S});

    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    check("sck_high_before_reset", sck_a, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_a", {req_a, und_a, ws_a, sck_a, sdo_a}, 0);
    check("async_reset_b", {req_b, und_b, ws_b, sck_b, sdo_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
